led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter LED_COUNT, default 4: number of LED channels, legal 1..16.
REQ-002 SHALL have parameter CLOCK_FREQ, default 100000000: clk frequency in Hz, a multiple of 1000.
REQ-003 SHALL have parameter PWM_BITS, default 8: brightness resolution, legal 1..8.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port LED, output, LED_COUNT bits: registered LED drive, one bit per channel.
REQ-007 SHALL have ASHI write ports: ashi_waddr in 32, ashi_wdata in 32, ashi_write in 1, ashi_wresp out 2, ashi_widle out 1.
REQ-008 SHALL have ASHI read ports: ashi_raddr in 32, ashi_read in 1, ashi_rdata out 32, ashi_rresp out 2, ashi_ridle out 1.

Function
REQ-009 SHALL decode the register index as addr[6:2] and ignore all other address bits.
REQ-010 SHALL define channel register n (index 0..LED_COUNT-1) as: bits[1:0] mode (0=off, 1=on, 2=blink, 3=blink-inverted); bits[15:8] duty, of which only the low PWM_BITS bits are used; bits[31:16] half-period in ms. Reads SHALL return the full 32 bits as written.
REQ-011 SHALL define index 30 as CTRL: a write with bit0=1 SHALL phase-sync all channels; reads SHALL return 0.
REQ-012 SHALL define index 31 as ID: reads SHALL return {16'hB11C, 8'(LED_COUNT), 8'(PWM_BITS)}; writes SHALL be ignored and return SLVERR (2).
REQ-013 SHALL return DECERR (3) for any other index, with no state change; all valid accesses SHALL return OKAY (0).
REQ-014 Read FSM SHALL have two states: IDLE and RESP. In IDLE with ashi_read=1, latch the index and go to RESP. RESP SHALL drive ashi_rdata/ashi_rresp and return to IDLE on the next clock.
REQ-015 Write FSM SHALL have two states: IDLE and COMMIT. In IDLE with ashi_write=1, latch the index and go to COMMIT. COMMIT SHALL update the register, drive ashi_wresp and return to IDLE on the next clock.
REQ-016 ashi_ridle SHALL be combinational: (ashi_read==0 && state==IDLE); ashi_widle likewise. Read and write SHALL run concurrently and independently.
REQ-017 SHALL generate a 1-clk ms_tick every CLOCK_FREQ/1000 clocks from a shared prescaler.
REQ-018 Per channel in blink modes, SHALL hold a 16-bit ms counter and a phase bit. On ms_tick: if counter+1 >= max(half-period,1), clear the counter and toggle phase; otherwise increment it.
REQ-019 SHALL run a free-running shared PWM_BITS-wide pwm_cnt that wraps from all-ones to 0.
REQ-020 SHALL define lit(n) as: mode0 -> 0; mode1 -> 1; mode2 -> phase; mode3 -> ~phase.
REQ-021 SHALL drive LED[n] registered as lit(n) && (duty==all-ones || pwm_cnt < duty). Hence duty 0 is always dark and duty all-ones is always fully on.
REQ-022 A committed write to channel n SHALL clear that channel's ms counter and set phase=1 in the same cycle.
REQ-023 A CTRL sync write SHALL clear the prescaler, pwm_cnt, and every ms counter, and set every phase=1, in the COMMIT cycle.
REQ-024 If ms_tick coincides with a COMMIT clear, the clear SHALL win.
REQ-025 Half-period 0 SHALL behave exactly like half-period 1.

Reset
REQ-026 While resetn=0: LED=0; every channel register=0 (off); ms counters, prescaler and pwm_cnt=0; phase=1; both FSMs IDLE; ashi_rdata=0; ashi_rresp=ashi_wresp=0.
REQ-027 Reset asserted mid-transaction SHALL abort it; no register update SHALL occur after reset is sampled.

Verification
REQ-028 After reset (CLOCK_FREQ=1000000): read idx 31 -> rdata 0xB11C0408, rresp 0; read idx 0 -> 0; LED stays 0.
REQ-029 Write idx0 = 0x0003FF01: LED[0] steady 1 from COMMIT+1. Write 0x00030001 (duty 0): LED[0] steady 0.
REQ-030 Write idx1 = 0x0005FF02: LED[1] high 5000 clk, low 5000 clk, repeating. Write the same value to idx2 mid-cycle, then CTRL=1: LED[1] and LED[2] transition on the same clock thereafter.
REQ-031 Write idx3 = 0x00008001 with PWM_BITS=8: LED[3] high exactly 128 of every 256 clocks.
REQ-032 Write idx 5 (LED_COUNT=4) -> wresp 3, no state change; write idx 31 -> wresp 2; simultaneous read of idx0 and write of idx1 both complete with OKAY; resetn pulsed during COMMIT leaves idx1 = 0.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: per-channel on/off/blink modes with PWM brightness,
// configured through independent ASHI read and write channels.
//
// Handshake: a request is accepted in the cycle its strobe (ashi_read or
// ashi_write) is high while the matching FSM is IDLE. The response is driven
// for exactly the following cycle (RESP / COMMIT), during which *_idle is low.
// Outside that response cycle the response outputs read as zero.
module led_pattern_ctrl #(
  parameter int LED_COUNT  = 4,
  parameter int CLOCK_FREQ = 100000000,
  parameter int PWM_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic [LED_COUNT-1:0] LED,
  input  logic [31:0]          ashi_waddr,
  input  logic [31:0]          ashi_wdata,
  input  logic                 ashi_write,
  output logic [1:0]           ashi_wresp,
  output logic                 ashi_widle,
  input  logic [31:0]          ashi_raddr,
  input  logic                 ashi_read,
  output logic [31:0]          ashi_rdata,
  output logic [1:0]           ashi_rresp,
  output logic                 ashi_ridle
);

  localparam int DIV = CLOCK_FREQ / 1000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [4:0] IDX_CTRL = 5'd30;
  localparam logic [4:0] IDX_ID = 5'd31;
  localparam logic [1:0] RESP_OKAY = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [31:0] ID_VAL = {16'hB11C, 8'(LED_COUNT), 8'(PWM_BITS)};

  typedef enum logic { R_IDLE, R_RESP } rstate_e;
  typedef enum logic { W_IDLE, W_COMMIT } wstate_e;

  rstate_e rstate_q, rstate_d;
  wstate_e wstate_q, wstate_d;
  logic [4:0]  ridx_q, ridx_d;
  logic [4:0]  widx_q, widx_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0]          chan_q [LED_COUNT];
  logic [LED_COUNT-1:0] ch_wr;
  logic                 sync_wr;
  logic [PRE_W-1:0]     pre_q;
  logic                 ms_tick;
  logic [PWM_BITS-1:0]  pwm_q;
  logic [LED_COUNT-1:0] led_d;

  // Only addr[6:2] selects a register; the rest is deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ashi_raddr[31:7], ashi_raddr[1:0],
                              ashi_waddr[31:7], ashi_waddr[1:0]};

  assign ashi_ridle = !ashi_read && (rstate_q == R_IDLE);
  assign ashi_widle = !ashi_write && (wstate_q == W_IDLE);

  // Read FSM state and latched index.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate_q <= R_IDLE;
      ridx_q   <= '0;
    end else begin
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
    end
  end

  // Read FSM: accept in IDLE, drive data/response for one RESP cycle.
  always_comb begin
    rstate_d   = rstate_q;
    ridx_d     = ridx_q;
    ashi_rdata = '0;
    ashi_rresp = RESP_OKAY;
    case (rstate_q)
      R_IDLE: begin
        if (ashi_read) begin
          ridx_d   = ashi_raddr[6:2];
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        rstate_d = R_IDLE;
        if (ridx_q == IDX_ID) begin
          ashi_rdata = ID_VAL;
        end else if (ridx_q != IDX_CTRL) begin
          ashi_rresp = RESP_DECERR;
          for (int i = 0; i < LED_COUNT; i++) begin
            if (ridx_q == 5'(i)) begin
              ashi_rdata = chan_q[i];
              ashi_rresp = RESP_OKAY;
            end
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write FSM state plus latched index and data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate_q <= W_IDLE;
      widx_q   <= '0;
      wdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
    end
  end

  // Write FSM: accept in IDLE, commit and respond in the COMMIT cycle.
  always_comb begin
    wstate_d   = wstate_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    ashi_wresp = RESP_OKAY;
    ch_wr      = '0;
    sync_wr    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (ashi_write) begin
          widx_d   = ashi_waddr[6:2];
          wdata_d  = ashi_wdata;
          wstate_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        wstate_d = W_IDLE;
        if (widx_q == IDX_ID) begin
          ashi_wresp = RESP_SLVERR;
        end else if (widx_q == IDX_CTRL) begin
          sync_wr = wdata_q[0];
        end else begin
          ashi_wresp = RESP_DECERR;
          for (int i = 0; i < LED_COUNT; i++) begin
            if (widx_q == 5'(i)) begin
              ch_wr[i]   = 1'b1;
              ashi_wresp = RESP_OKAY;
            end
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Channel configuration registers, updated only in COMMIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < LED_COUNT; i++) chan_q[i] <= '0;
    end else begin
      for (int i = 0; i < LED_COUNT; i++) begin
        if (ch_wr[i]) chan_q[i] <= wdata_q;
      end
    end
  end

  assign ms_tick = (pre_q == PRE_MAX);

  // Millisecond prescaler; a sync write restarts it from zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
    end else if (sync_wr || ms_tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Free-running PWM ramp shared by all channels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwm_q <= '0;
    end else if (sync_wr) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_BITS'(1);
    end
  end

  for (genvar g = 0; g < LED_COUNT; g++) begin : g_ch
    logic [15:0]         hp_eff;
    logic [15:0]         cnt_q;
    logic                phase_q;
    logic [PWM_BITS-1:0] duty;
    logic                lit;

    // A half-period of 0 is treated as 1 ms.
    assign hp_eff = (chan_q[g][31:16] == 16'd0) ? 16'd1 : chan_q[g][31:16];
    assign duty   = chan_q[g][8 +: PWM_BITS];
    assign lit    = (chan_q[g][1:0] == 2'd0) ? 1'b0 :
                    (chan_q[g][1:0] == 2'd1) ? 1'b1 :
                    (chan_q[g][1:0] == 2'd2) ? phase_q : ~phase_q;
    assign led_d[g] = lit && ((duty == '1) || (pwm_q < duty));

    // Blink timer: a commit clear takes priority over a coincident tick.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        cnt_q   <= '0;
        phase_q <= 1'b1;
      end else if (ch_wr[g] || sync_wr) begin
        cnt_q   <= '0;
        phase_q <= 1'b1;
      end else if (ms_tick) begin
        if (({1'b0, cnt_q} + 17'd1) >= {1'b0, hp_eff}) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  // Registered LED drive.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      LED <= '0;
    end else begin
      LED <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl (4 channels, 1 MHz, 8-bit PWM).
module tb_led_pattern_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  LED;
  logic [31:0] ashi_waddr = '0;
  logic [31:0] ashi_wdata = '0;
  logic        ashi_write = 1'b0;
  logic [1:0]  ashi_wresp;
  logic        ashi_widle;
  logic [31:0] ashi_raddr = '0;
  logic        ashi_read = 1'b0;
  logic [31:0] ashi_rdata;
  logic [1:0]  ashi_rresp;
  logic        ashi_ridle;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {rresp, rdata}
  logic [1:0]  exp_wq[$];  // wresp
  logic [31:0] shadow [4];

  led_pattern_ctrl #(.LED_COUNT(4), .CLOCK_FREQ(1000000), .PWM_BITS(8)) dut (
    .clk(clk), .resetn(resetn), .LED(LED),
    .ashi_waddr(ashi_waddr), .ashi_wdata(ashi_wdata), .ashi_write(ashi_write),
    .ashi_wresp(ashi_wresp), .ashi_widle(ashi_widle),
    .ashi_raddr(ashi_raddr), .ashi_read(ashi_read), .ashi_rdata(ashi_rdata),
    .ashi_rresp(ashi_rresp), .ashi_ridle(ashi_ridle)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    @(negedge clk);
    ashi_raddr = addr;
    ashi_read = 1'b1;
    @(posedge clk); #1;
    ashi_read = 1'b0;
    d = ashi_rdata;
    r = ashi_rresp;
    @(posedge clk); #1;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] r);
    @(negedge clk);
    ashi_waddr = addr;
    ashi_wdata = data;
    ashi_write = 1'b1;
    @(posedge clk); #1;
    ashi_write = 1'b0;
    r = ashi_wresp;
    @(posedge clk); #1;
  endtask

  // Count consecutive samples (one per clock) where LED[b] == level.
  task automatic measure_run(input int b, input logic level, input int limit, output int len);
    len = 0;
    while (LED[b] === level && len < limit) begin
      len++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (LED !== 4'b0) begin errors++; $display("FAIL reset_led: got %b expected 0000", LED); end
    checks++;
    if ({ashi_rresp, ashi_rdata} !== 34'd0) begin
      errors++; $display("FAIL reset_rdata: got %h/%0d expected 0/0", ashi_rdata, ashi_rresp);
    end
    checks++;
    if (ashi_wresp !== 2'd0) begin errors++; $display("FAIL reset_wresp: got %0d expected 0", ashi_wresp); end
    checks++;
    if ({ashi_ridle, ashi_widle} !== 2'b11) begin
      errors++; $display("FAIL reset_idle: got %b expected 11", {ashi_ridle, ashi_widle});
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
  endtask

  task automatic test_id_read();
    logic [31:0] addr_t [5];
    logic [33:0] exp_t [5];
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    int bad;
    addr_t = '{32'h7C, 32'h00, 32'h78, 32'h14, 32'h0C};
    exp_t  = '{{2'd0, 32'hB11C0408}, 34'd0, 34'd0, {2'd3, 32'h0}, 34'd0};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exp_t[i]);
      drive_read(addr_t[i], d, r);
      e = exp_q.pop_front();
      checks++;
      if ({r, d} !== e) begin
        errors++; $display("FAIL id_read[%0h]: got %0d/%h expected %0d/%h", addr_t[i], r, d, e[33:32], e[31:0]);
      end
    end
    bad = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (LED !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL led_dark_after_reset: got %0d lit cycles expected 0", bad); end
  endtask

  task automatic test_steady();
    logic [31:0] data_t [2];
    logic [1:0] r;
    logic [1:0] e;
    int bad;
    data_t = '{32'h0003FF01, 32'h00030001};
    for (int k = 0; k < 2; k++) begin
      exp_wq.push_back(2'd0);
      drive_write(32'h00, data_t[k], r);
      e = exp_wq.pop_front();
      checks++;
      if (r !== e) begin errors++; $display("FAIL steady_wresp[%0d]: got %0d expected %0d", k, r, e); end
      shadow[0] = data_t[k];
      @(posedge clk); #1;
      bad = 0;
      repeat (2000) begin
        if (LED[0] !== (k == 0)) bad++;
        @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL steady_led[%0d]: got %0d wrong cycles expected 0", k, bad); end
    end
  endtask

  task automatic test_pwm();
    logic [7:0] duty_t [4];
    int exp_t [4];
    logic [1:0] r;
    int highs;
    duty_t = '{8'h80, 8'h01, 8'h00, 8'hFF};
    exp_t  = '{128, 1, 0, 256};
    for (int k = 0; k < 4; k++) begin
      exp_wq.push_back(2'd0);
      drive_write(32'h0C, {16'h0000, duty_t[k], 8'h01}, r);
      shadow[3] = {16'h0000, duty_t[k], 8'h01};
      checks++;
      if (r !== exp_wq.pop_front()) begin errors++; $display("FAIL pwm_wresp[%0d]: got %0d expected 0", k, r); end
      @(posedge clk); #1;
      highs = 0;
      repeat (256) begin
        if (LED[3] === 1'b1) highs++;
        @(posedge clk); #1;
      end
      checks++;
      if (highs != exp_t[k]) begin
        errors++; $display("FAIL pwm_duty_%02h: got %0d high of 256 expected %0d", duty_t[k], highs, exp_t[k]);
      end
    end
  endtask

  task automatic test_blink();
    logic [1:0] r;
    int len;
    exp_wq.push_back(2'd0);
    drive_write(32'h04, 32'h0005FF02, r);
    shadow[1] = 32'h0005FF02;
    checks++;
    if (r !== exp_wq.pop_front()) begin errors++; $display("FAIL blink_wresp: got %0d expected 0", r); end
    @(posedge clk); #1;
    measure_run(1, 1'b1, 6000, len);
    checks++;
    if (len < 4000 || len > 5000) begin errors++; $display("FAIL blink_first_high: got %0d expected 4000..5000", len); end
    measure_run(1, 1'b0, 6000, len);
    checks++;
    if (len != 5000) begin errors++; $display("FAIL blink_low: got %0d expected 5000", len); end
    measure_run(1, 1'b1, 6000, len);
    checks++;
    if (len != 5000) begin errors++; $display("FAIL blink_high: got %0d expected 5000", len); end
    // half-period 0 behaves like 1 ms
    exp_wq.push_back(2'd0);
    drive_write(32'h08, 32'h0000FF02, r);
    shadow[2] = 32'h0000FF02;
    checks++;
    if (r !== exp_wq.pop_front()) begin errors++; $display("FAIL hp0_wresp: got %0d expected 0", r); end
    @(posedge clk); #1;
    measure_run(2, 1'b1, 2000, len);
    checks++;
    if (len < 1 || len > 1000) begin errors++; $display("FAIL hp0_first_high: got %0d expected 1..1000", len); end
    measure_run(2, 1'b0, 2000, len);
    checks++;
    if (len != 1000) begin errors++; $display("FAIL hp0_low: got %0d expected 1000", len); end
  endtask

  task automatic test_sync();
    logic [1:0] r;
    int len, bad, edges;
    logic prev;
    repeat (1234) @(posedge clk);
    #1;
    exp_wq.push_back(2'd0);
    drive_write(32'h08, 32'h0005FF02, r);
    shadow[2] = 32'h0005FF02;
    checks++;
    if (r !== exp_wq.pop_front()) begin errors++; $display("FAIL sync_idx2_wresp: got %0d expected 0", r); end
    repeat (777) @(posedge clk);
    #1;
    exp_wq.push_back(2'd0);
    drive_write(32'h78, 32'h00000001, r);
    checks++;
    if (r !== exp_wq.pop_front()) begin errors++; $display("FAIL sync_ctrl_wresp: got %0d expected 0", r); end
    @(posedge clk); #1;
    bad = 0;
    len = 0;
    while (LED[1] === 1'b1 && len < 6000) begin
      if (LED[2] !== LED[1]) bad++;
      len++;
      @(posedge clk); #1;
    end
    checks++;
    if (len != 5000) begin errors++; $display("FAIL sync_first_high: got %0d expected 5000", len); end
    edges = 0;
    prev = LED[1];
    repeat (11000) begin
      if (LED[2] !== LED[1]) bad++;
      if (LED[1] !== prev) edges++;
      prev = LED[1];
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sync_align: got %0d differing cycles expected 0", bad); end
    checks++;
    if (edges != 2) begin errors++; $display("FAIL sync_edges: got %0d transitions expected 2", edges); end
  endtask

  task automatic test_errors();
    logic [31:0] waddr_t [3];
    logic [31:0] wdata_t [3];
    logic [1:0]  wexp_t [3];
    logic [31:0] raddr_t [6];
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] e;
    waddr_t = '{32'h14, 32'h7C, 32'hABCDE000};
    wdata_t = '{32'hFFFFFFFF, 32'h00000000, 32'h00AB0001};
    wexp_t  = '{2'd3, 2'd2, 2'd0};
    for (int k = 0; k < 3; k++) begin
      exp_wq.push_back(wexp_t[k]);
      drive_write(waddr_t[k], wdata_t[k], r);
      checks++;
      if (r !== exp_wq.pop_front()) begin
        errors++; $display("FAIL err_wresp[%h]: got %0d expected %0d", waddr_t[k], r, wexp_t[k]);
      end
    end
    shadow[0] = 32'h00AB0001;
    raddr_t = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h12345F80, 32'h7C};
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp_q.push_back({2'd0, shadow[k]});
      else if (k == 4) exp_q.push_back({2'd0, shadow[0]});
      else exp_q.push_back({2'd0, 32'hB11C0408});
      drive_read(raddr_t[k], d, r);
      e = exp_q.pop_front();
      checks++;
      if ({r, d} !== e) begin
        errors++; $display("FAIL err_readback[%h]: got %0d/%h expected %0d/%h", raddr_t[k], r, d, e[33:32], e[31:0]);
      end
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    logic [1:0] rr, wr;
    logic [33:0] e;
    exp_q.push_back({2'd0, shadow[0]});
    exp_wq.push_back(2'd0);
    @(negedge clk);
    ashi_raddr = 32'h00;
    ashi_read = 1'b1;
    ashi_waddr = 32'h04;
    ashi_wdata = 32'h0007FF03;
    ashi_write = 1'b1;
    @(posedge clk); #1;
    ashi_read = 1'b0;
    ashi_write = 1'b0;
    d = ashi_rdata;
    rr = ashi_rresp;
    wr = ashi_wresp;
    @(posedge clk); #1;
    shadow[1] = 32'h0007FF03;
    e = exp_q.pop_front();
    checks++;
    if ({rr, d} !== e) begin errors++; $display("FAIL conc_read: got %0d/%h expected %0d/%h", rr, d, e[33:32], e[31:0]); end
    checks++;
    if (wr !== exp_wq.pop_front()) begin errors++; $display("FAIL conc_wresp: got %0d expected 0", wr); end
    exp_q.push_back({2'd0, shadow[1]});
    drive_read(32'h04, d, rr);
    e = exp_q.pop_front();
    checks++;
    if ({rr, d} !== e) begin errors++; $display("FAIL conc_readback: got %0d/%h expected %0d/%h", rr, d, e[33:32], e[31:0]); end
  endtask

  task automatic test_reset_commit();
    logic [31:0] d;
    logic [1:0] r;
    logic [33:0] e;
    @(negedge clk);
    ashi_waddr = 32'h04;
    ashi_wdata = 32'h12345678;
    ashi_write = 1'b1;
    @(posedge clk); #1;
    ashi_write = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ashi_wresp !== 2'd0) begin errors++; $display("FAIL rst_commit_wresp: got %0d expected 0", ashi_wresp); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    exp_q.push_back({2'd0, shadow[1]});
    drive_read(32'h04, d, r);
    e = exp_q.pop_front();
    checks++;
    if ({r, d} !== e) begin errors++; $display("FAIL rst_commit_idx1: got %0d/%h expected %0d/%h", r, d, e[33:32], e[31:0]); end
    checks++;
    if (LED !== 4'b0) begin errors++; $display("FAIL rst_commit_led: got %b expected 0000", LED); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_id_read();
    test_steady();
    test_pwm();
    test_blink();
    test_sync();
    test_errors();
    test_concurrent();
    test_reset_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
